// File: rtl/hilo_div_ctrl.sv
// hilo_div_ctrl: radix-2 restoring DIV/DIVU sequencer driving the HI/LO write port.
// Optional DIV_FASTZERO_EN: divide-by-zero bypasses the RUN iterations.
module hilo_div_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic             signed_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             annul_i,
    output logic             stall_o,
    output logic             busy_o,
    output logic             hilo_we_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);
    localparam int CW = $clog2(WIDTH) + 1;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d, quot_q, quot_d, div_q, div_d, hi_q, hi_d, lo_q, lo_d;
    logic             qs_q, qs_d, rs_q, rs_d, fz_q, fz_d;
    logic             accept;
    logic [WIDTH-1:0] a_mag, b_mag, res_hi, res_lo;
    logic [WIDTH:0]   sh, diff;

    assign a_mag  = (signed_i && a_i[WIDTH-1]) ? -a_i : a_i;
    assign b_mag  = (signed_i && b_i[WIDTH-1]) ? -b_i : b_i;
    assign accept = (state_q == IDLE) && start_i && !annul_i;
    assign sh     = {rem_q, quot_q[WIDTH-1]};
    assign diff   = sh - {1'b0, div_q};
    assign res_lo = qs_q ? -quot_q : quot_q;
    assign res_hi = rs_q ? -rem_q : rem_q;

    assign busy_o    = state_q != IDLE;
    assign stall_o   = accept || (state_q == RUN);
    // fz_q marks the settle cycle of a fast divide-by-zero, which must not write yet
    assign hilo_we_o = (state_q == DONE) && !annul_i && !fz_q;
    assign hi_o      = hilo_we_o ? res_hi : hi_q;
    assign lo_o      = hilo_we_o ? res_lo : lo_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        quot_d  = quot_q;
        div_d   = div_q;
        qs_d    = qs_q;
        rs_d    = rs_q;
        fz_d    = fz_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            IDLE: if (accept) begin
                div_d   = b_mag;
                quot_d  = a_mag;
                rem_d   = '0;
                cnt_d   = '0;
                qs_d    = (a_i[WIDTH-1] ^ b_i[WIDTH-1]) & signed_i;
                rs_d    = a_i[WIDTH-1] & signed_i;
                state_d = RUN;
`ifdef DIV_FASTZERO_EN
                if (b_i == '0) begin
                    quot_d  = '1;
                    rem_d   = a_mag;
                    fz_d    = 1'b1;
                    state_d = DONE;
                end
`endif
            end
            RUN: begin
                rem_d   = diff[WIDTH] ? sh[WIDTH-1:0] : diff[WIDTH-1:0];
                quot_d  = {quot_q[WIDTH-2:0], ~diff[WIDTH]};
                cnt_d   = cnt_q + 1'b1;
                state_d = annul_i ? IDLE : (cnt_q == CW'(WIDTH - 1)) ? DONE : RUN;
            end
            DONE: begin
                fz_d    = 1'b0;
                state_d = (fz_q && !annul_i) ? DONE : IDLE;
                hi_d    = hilo_we_o ? res_hi : hi_q;
                lo_d    = hilo_we_o ? res_lo : lo_q;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            quot_q  <= '0;
            div_q   <= '0;
            qs_q    <= 1'b0;
            rs_q    <= 1'b0;
            fz_q    <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            quot_q  <= quot_d;
            div_q   <= div_d;
            qs_q    <= qs_d;
            rs_q    <= rs_d;
            fz_q    <= fz_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end
endmodule

// File: doc/hilo_div_ctrl.md
Name: hilo_div_ctrl

Overview:
Multi-cycle divide sequencer that owns the HI/LO write path for DIV/DIVU.
- Accepts a divide request from the execute stage.
- Runs a radix-2 restoring division, one quotient bit per cycle.
- Stalls the pipeline while it runs.
- Issues a single HI/LO write pulse carrying remainder (HI) and quotient (LO).
- Sits beside the ALU in the execute stage; the controller drives start/signed/annul.
- The hazard logic consumes stall_o.

Parameters:
WIDTH, 32, operand/result width; iteration count equals WIDTH.

Ports:
clk  input  1  system clock; all state changes on rising edge.
rst  input  1  synchronous, active-high reset.
start_i  input  1  divide request from execute stage; sampled only in IDLE.
signed_i  input  1  1 = DIV (two's complement), 0 = DIVU.
a_i  input  WIDTH  dividend (rs value); captured on accepted start.
b_i  input  WIDTH  divisor (rt value); captured on accepted start.
annul_i  input  1  flush/exception; aborts an in-flight divide.
stall_o  output  1  freeze fetch/decode/execute while divide is pending.
busy_o  output  1  state != IDLE.
hilo_we_o  output  1  one-cycle write strobe for HI/LO registers.
hi_o  output  WIDTH  remainder; valid while hilo_we_o=1, held afterwards.
lo_o  output  WIDTH  quotient; valid while hilo_we_o=1, held afterwards.

Behaviour:
- Reset values: state=IDLE; stall_o=0, busy_o=0, hilo_we_o=0; hi_o=0, lo_o=0; iteration counter=0.
- States: IDLE, RUN, DONE.
- IDLE:
  - On start_i=1 and annul_i=0, capture |a|, |b| (magnitudes if signed_i, raw otherwise), the quotient sign (a[MSB]^b[MSB])&signed_i and the remainder sign a[MSB]&signed_i.
  - Clear the partial remainder and counter, then go to RUN.
  - start_i=1 with annul_i=1 is ignored.
- RUN:
  - Each cycle, shift {rem,quot} left by 1.
  - If rem' >= |b|, subtract |b| and set quot[0]=1.
  - Use a WIDTH+1-bit subtractor so there is no overflow.
  - Counter increments each cycle; after exactly WIDTH RUN cycles, go to DONE.
- DONE:
  - Apply sign fix-up: lo_o = quotient negated if quotient sign, hi_o = remainder negated if remainder sign.
  - Assert hilo_we_o for exactly this cycle, then go to IDLE.
- Latency: start accepted at edge 0, RUN for edges 1..WIDTH, hilo_we_o high in cycle WIDTH+1 (33 for WIDTH=32). A new start may be accepted in the cycle after DONE.
- stall_o = (IDLE & start_i & ~annul_i) | RUN. It is combinational so the DIV instruction holds in execute from its first cycle. It is low in DONE, so the pipeline advances on the cycle of the write.
- start_i while busy_o=1 is ignored; no queueing.
- annul_i=1 in RUN:
  - Next state is IDLE, with no hilo_we_o.
  - hi_o/lo_o keep their previous values.
- annul_i=1 in DONE: the write is suppressed (hilo_we_o gated to 0) and the next state is IDLE.
- Divide by zero (natural restoring result, no trap):
  - Unsigned: lo=all ones, hi=a.
  - Signed: lo = a<0 ? 1 : all ones, hi=a.
- Signed overflow, 0x80000000 / -1: lo=0x80000000, hi=0.
- rst=1 in any state returns to IDLE next edge; all outputs take their reset values.

Optional Feature:
DIV_FASTZERO_EN:
- Defined: an accepted start with b_i==0 goes directly IDLE->DONE, skipping RUN. hilo_we_o fires 2 cycles after start is accepted, with the divide-by-zero values above. stall_o covers only the accept cycle.
- Undefined: divide-by-zero takes the full WIDTH+1 cycle path. Result values are identical in both builds.

Test Plan:
1. DIVU a=100, b=7, start one cycle -> stall_o high cycles 0..32, hilo_we_o high cycle 33 only; lo=14, hi=2.
2. DIV a=-7 (0xFFFFFFF9), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. Also DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
3. DIVU a=5, b=0 -> lo=0xFFFFFFFF, hi=5. DIV a=-5, b=0 -> lo=1, hi=0xFFFFFFFB. With DIV_FASTZERO_EN: hilo_we_o in cycle 2; without it: cycle 33.
4. Start DIVU 100/7, assert annul_i in cycle 10 -> busy_o=0 from cycle 11, no hilo_we_o, hi/lo retain prior values. Second start in cycle 12 completes normally in cycle 45.
5. Start DIVU 100/7; hold start_i=1 with new operands 9/3 throughout RUN -> only one write (14, 2) in cycle 33. The held start is accepted in cycle 34, giving a write of 3, 0 in cycle 67.
6. Assert rst in cycle 15 of a divide -> cycle 16: busy_o=0, stall_o=0, hi_o=lo_o=0, no hilo_we_o until a fresh start completes.
